// File: rtl/acc_mac16_if.sv
`default_nettype none
// ============================================================================
//  Module   : acc_mac16_if
//  Purpose  : Signal bundle between the 16-step sequencer side (master) and
//             the acc_mac16 neuron accumulator (slave).
//  Signals  : state[3:0]  step index from the sequencer
//             en          enable; low aborts the running sequence
//             x_vec       16 packed signed inputs,  element i at [i*X_W +: X_W]
//             w_vec       16 packed signed weights, same packing
//             bias        signed bias, loaded with index 0
//             y           saturated ReLU neuron output
//             y_valid     one-cycle pulse when y updates
//             busy        accumulator is mid-sequence
//             sync_err    one-cycle pulse on an out-of-order index
//  Revision : 1.0  initial release
// ============================================================================
interface acc_mac16_if #(
    parameter int X_W   = 8,
    parameter int W_W   = 8,
    parameter int ACC_W = 20,
    parameter int OUT_W = 8
) ();
    logic [3:0]        state;
    logic              en;
    logic [16*X_W-1:0] x_vec;
    logic [16*W_W-1:0] w_vec;
    logic [ACC_W-1:0]  bias;
    logic [OUT_W-1:0]  y;
    logic              y_valid;
    logic              busy;
    logic              sync_err;

    modport master (
        output state, en, x_vec, w_vec, bias,
        input  y, y_valid, busy, sync_err
    );

    modport slave (
        input  state, en, x_vec, w_vec, bias,
        output y, y_valid, busy, sync_err
    );
endinterface
`default_nettype wire

// File: rtl/acc_mac16.sv
`default_nettype none
// ============================================================================
//  Module   : acc_mac16
//  Purpose  : Consumer of the 16-step sequencer index. Adds one signed
//             product x[i]*w[i] per index change (plus a bias at index 0),
//             then emits a ReLU-saturated neuron output after index 15.
//             Out-of-order indices are flagged and the term is discarded.
//  Ports    : clk           clock
//             rst           asynchronous active-high reset
//             bus (slave)   state/en/x_vec/w_vec/bias in,
//                           y/y_valid/busy/sync_err out
//  Revision : 1.0  initial release
// ============================================================================
module acc_mac16 #(
    parameter int X_W   = 8,
    parameter int W_W   = 8,
    parameter int ACC_W = 20,
    parameter int OUT_W = 8,
    parameter int SHIFT = 4
) (
    input  logic        clk,
    input  logic        rst,
    acc_mac16_if.slave  bus
);

    localparam int N_STEPS = 16;
    localparam int PROD_W  = X_W + W_W;
    localparam logic [ACC_W-1:0] Y_MAX = ACC_W'((64'd1 << OUT_W) - 64'd1);
    localparam logic [3:0] LAST_IDX = 4'd15;

    typedef enum logic [1:0] {
        ST_WAIT0 = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } fsm_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    fsm_t             fsm_q,        fsm_d;
    logic [ACC_W-1:0] acc_q,        acc_d;
    logic [3:0]       expect_idx_q, expect_idx_d;
    logic [3:0]       prev_state_q, prev_state_d;
    logic [OUT_W-1:0] y_q,          y_d;
    logic             y_valid_q,    y_valid_d;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    logic                     strobe;
    logic                     sync_err_w;
    logic signed [X_W-1:0]    x_elem [N_STEPS];
    logic signed [W_W-1:0]    w_elem [N_STEPS];
    logic signed [X_W-1:0]    x_sel;
    logic signed [W_W-1:0]    w_sel;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  term;
    logic signed [ACC_W-1:0]  acc_shr;
    logic [OUT_W-1:0]         y_sat;

    generate
        for (genvar gi = 0; gi < N_STEPS; gi++) begin : g_unpack
            assign x_elem[gi] = bus.x_vec[gi*X_W +: X_W];
            assign w_elem[gi] = bus.w_vec[gi*W_W +: W_W];
        end
    endgenerate

    // One index change is one step, however long the sequencer dwells.
    assign strobe = (bus.state != prev_state_q);

    // The current product, sign-extended to the accumulator width.
    assign x_sel = x_elem[bus.state];
    assign w_sel = w_elem[bus.state];
    assign prod  = PROD_W'(x_sel) * PROD_W'(w_sel);
    assign term  = ACC_W'(prod);

    // Output scaling: arithmetic shift, clamp negatives to 0, clamp the top.
    assign acc_shr = $signed(acc_q) >>> SHIFT;

    always_comb begin
        y_sat = '0;
        if (acc_shr[ACC_W-1]) begin
            y_sat = '0;
        end else if ($unsigned(acc_shr) > Y_MAX) begin
            y_sat = Y_MAX[OUT_W-1:0];
        end else begin
            y_sat = acc_shr[OUT_W-1:0];
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        fsm_d        = fsm_q;
        acc_d        = acc_q;
        expect_idx_d = expect_idx_q;
        prev_state_d = bus.state;
        y_d          = y_q;
        y_valid_d    = 1'b0;
        sync_err_w   = 1'b0;

        case (fsm_q)
            ST_WAIT0: begin
                // Only a fresh index 0 opens a sequence; anything else is
                // the tail of an aborted round and is dropped quietly.
                if (strobe && bus.en && (bus.state == 4'd0)) begin
                    acc_d        = bus.bias + term;
                    expect_idx_d = 4'd1;
                    fsm_d        = ST_ACCUM;
                end
            end

            ST_ACCUM: begin
                if (!bus.en) begin
                    fsm_d = ST_WAIT0;
                end else if (strobe) begin
                    if (bus.state == expect_idx_q) begin
                        acc_d        = acc_q + term;
                        expect_idx_d = expect_idx_q + 4'd1;
                        if (bus.state == LAST_IDX) begin
                            fsm_d = ST_DONE;
                        end
                    end else begin
                        sync_err_w = 1'b1;
                        // A jump back to 0 is a new round starting now, so
                        // take its bias and first term without a lost step.
                        if (bus.state == 4'd0) begin
                            acc_d        = bus.bias + term;
                            expect_idx_d = 4'd1;
                        end else begin
                            fsm_d = ST_WAIT0;
                        end
                    end
                end
            end

            ST_DONE: begin
                y_d       = y_sat;
                y_valid_d = 1'b1;
                fsm_d     = ST_WAIT0;
            end

            default: begin
                fsm_d = ST_WAIT0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q        <= ST_WAIT0;
            acc_q        <= '0;
            expect_idx_q <= 4'd0;
            // All-ones so an index 0 already present at release is a change.
            prev_state_q <= 4'hF;
            y_q          <= '0;
            y_valid_q    <= 1'b0;
        end else begin
            fsm_q        <= fsm_d;
            acc_q        <= acc_d;
            expect_idx_q <= expect_idx_d;
            prev_state_q <= prev_state_d;
            y_q          <= y_d;
            y_valid_q    <= y_valid_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.y        = y_q;
    assign bus.y_valid  = y_valid_q;
    assign bus.busy     = (fsm_q == ST_ACCUM) || (fsm_q == ST_DONE);
    assign bus.sync_err = sync_err_w;

endmodule
`default_nettype wire
